// File: rtl/screensaver_pkg.sv
// Shared types and helpers for the screensaver sequencer: the FSM state
// encoding (also exported on the debug port), brightness limits and the
// image-index wrap rule.
package screensaver_pkg;

    // Encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        LOAD     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [3:0] BRIGHT_MAX = 4'd15;
    localparam logic [3:0] BRIGHT_MIN = 4'd0;

    // Index of the image that follows cur, wrapping back to 0 after the last
    // of n sources. With a single source the result is always 0.
    function automatic int unsigned next_image(input int unsigned cur,
                                               input int unsigned n);
        if (cur + 1 >= n) begin
            return 0;
        end
        return cur + 1;
    endfunction

endpackage

// File: rtl/brightness_ramp.sv
// Four-bit brightness level that moves up or down by one per request.
// Requests are already qualified with frame_tick by the parent, so the
// level moves at most once per frame. The limits are enforced here, so
// the level never wraps.
module brightness_ramp
    import screensaver_pkg::*;
(
    input  logic       clk_25_175,
    input  logic       rst,
    input  logic       step_up,
    input  logic       step_down,
    output logic [3:0] brightness,
    output logic       at_max,
    output logic       at_min
);

    logic [3:0] level_q;

    // Brightness register: full brightness out of reset, saturating steps.
    always_ff @(posedge clk_25_175) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, whatever order the blocks run in.
        if (rst) begin
            level_q <= BRIGHT_MAX;
        end else if (step_up && !step_down && (level_q != BRIGHT_MAX)) begin
            level_q <= level_q + 4'd1;
        end else if (step_down && !step_up && (level_q != BRIGHT_MIN)) begin
            level_q <= level_q - 4'd1;
        end
    end

    assign brightness = level_q;
    assign at_max     = (level_q == BRIGHT_MAX);
    assign at_min     = (level_q == BRIGHT_MIN);

endmodule

// File: rtl/screensaver_sequencer.sv
// Frame-level screensaver controller. Shows the current image for a fixed
// number of frames, fades to black, selects the next image and kicks its
// renderer, waits for the completion handshake (or gives up after a frame
// budget), then fades back in. Every output is registered.
module screensaver_sequencer
    import screensaver_pkg::*;
#(
    parameter int  NUM_IMAGES            = 2,
    parameter int  FRAMES_PER_IMAGE      = 480,
    parameter int  RENDER_TIMEOUT_FRAMES = 8,
    parameter int  START_IMAGE           = 0,
    localparam int IW                    = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic          clk_25_175,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          pause,
    input  logic          skip,
    input  logic          render_done,
    output logic [IW-1:0] image_sel,
    output logic          render_start,
    output logic [3:0]    brightness,
    output logic          render_timeout,
    output logic [1:0]    state
);

    // ------------------------------------------------------------------
    // Parameter sanity: bad values stop elaboration.
    // ------------------------------------------------------------------
    if (NUM_IMAGES < 1) begin : g_bad_num_images
        $error("screensaver_sequencer: NUM_IMAGES must be at least 1");
    end
    if (FRAMES_PER_IMAGE < 1) begin : g_bad_frames_per_image
        $error("screensaver_sequencer: FRAMES_PER_IMAGE must be at least 1");
    end
    if (RENDER_TIMEOUT_FRAMES < 1) begin : g_bad_render_timeout
        $error("screensaver_sequencer: RENDER_TIMEOUT_FRAMES must be at least 1");
    end
    if ((START_IMAGE < 0) || (START_IMAGE >= NUM_IMAGES)) begin : g_bad_start_image
        $error("screensaver_sequencer: START_IMAGE must be below NUM_IMAGES");
    end

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int FCW = $clog2(FRAMES_PER_IMAGE + 1);
    localparam int WCW = $clog2(RENDER_TIMEOUT_FRAMES + 1);

    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_IMAGE - 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(RENDER_TIMEOUT_FRAMES - 1);
    localparam logic [IW-1:0]  START_SEL  = IW'(START_IMAGE);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]  image_sel_q, image_sel_d;
    logic           render_start_q, render_start_d;
    logic           render_timeout_q, render_timeout_d;

    // Brightness ramp interface
    logic           step_up, step_down;
    logic [3:0]     brightness_q;
    logic           at_max, at_min;

    // ------------------------------------------------------------------
    // Event decode shared by the next-state and output logic
    // ------------------------------------------------------------------
    logic show_expire;    // last full-brightness frame has been shown
    logic fade_out_last;  // this tick takes brightness 1 -> 0
    logic fade_in_last;   // this tick takes brightness 14 -> 15
    logic done_accept;    // completion handshake that counts
    logic wait_expire;    // render budget used up without a handshake

    assign show_expire   = frame_tick && !pause && (frame_cnt_q == FRAME_LAST);
    assign fade_out_last = frame_tick && (brightness_q == (BRIGHT_MIN + 4'd1));
    assign fade_in_last  = frame_tick && (brightness_q == (BRIGHT_MAX - 4'd1));
    // A done arriving alongside the start pulse cannot belong to this render.
    assign done_accept   = render_done && !render_start_q;
    // A handshake in the same cycle as the final tick wins over the timeout.
    assign wait_expire   = frame_tick && !done_accept && (wait_cnt_q == WAIT_LAST);

    // State register: reset returns to SHOW from anywhere, abandoning a render.
    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            state_q <= SHOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transition condition per phase of the show.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            SHOW: begin
                if (skip || show_expire) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (fade_out_last) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (done_accept || wait_expire) begin
                    state_d = FADE_IN;
                end
            end
            FADE_IN: begin
                if (fade_in_last) begin
                    state_d = SHOW;
                end
            end
            default: begin
                state_d = SHOW;
            end
        endcase
    end

    // Output logic: counter updates, image selection, handshake pulses and
    // brightness steps for the current state.
    always_comb begin
        frame_cnt_d      = frame_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        image_sel_d      = image_sel_q;
        render_start_d   = 1'b0;
        render_timeout_d = 1'b0;
        step_up          = 1'b0;
        step_down        = 1'b0;
        case (state_q)
            SHOW: begin
                // skip takes priority over the tick and ignores pause.
                if (skip || show_expire) begin
                    frame_cnt_d = '0;
                end else if (frame_tick && !pause) begin
                    frame_cnt_d = frame_cnt_q + FCW'(1);
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    step_down = !at_min;
                    if (fade_out_last) begin
                        image_sel_d    = IW'(next_image(32'(image_sel_q), NUM_IMAGES));
                        render_start_d = 1'b1;
                        wait_cnt_d     = '0;
                    end
                end
            end
            LOAD: begin
                // Brightness stays at black; only the wait budget advances.
                if (!done_accept && frame_tick) begin
                    if (wait_expire) begin
                        render_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    step_up = !at_max;
                    if (fade_in_last) begin
                        frame_cnt_d = '0;
                    end
                end
            end
            default: begin
                frame_cnt_d = '0;
            end
        endcase
    end

    // Datapath registers: counters, image index and the one-cycle pulses.
    always_ff @(posedge clk_25_175) begin
        if (rst) begin
            frame_cnt_q      <= '0;
            wait_cnt_q       <= '0;
            image_sel_q      <= START_SEL;
            render_start_q   <= 1'b0;
            render_timeout_q <= 1'b0;
        end else begin
            frame_cnt_q      <= frame_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            image_sel_q      <= image_sel_d;
            render_start_q   <= render_start_d;
            render_timeout_q <= render_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Brightness ramp
    // ------------------------------------------------------------------
    brightness_ramp u_brightness_ramp (
        .clk_25_175 (clk_25_175),
        .rst        (rst),
        .step_up    (step_up),
        .step_down  (step_down),
        .brightness (brightness_q),
        .at_max     (at_max),
        .at_min     (at_min)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign image_sel      = image_sel_q;
    assign render_start   = render_start_q;
    assign brightness     = brightness_q;
    assign render_timeout = render_timeout_q;
    assign state          = state_q;

endmodule

// File: tb/tb_screensaver_sequencer.sv
// Self-checking bench for screensaver_sequencer. A behavioural model of
// the show sequence predicts every output each cycle; directed phases walk
// the key scenarios, then a randomized phase exercises arbitrary mixes of
// ticks, pause, skip, render_done and reset.
module tb_screensaver_sequencer;

    localparam int N_IMG  = 2;
    localparam int FPI    = 4;
    localparam int RT     = 3;
    localparam int START  = 0;

    localparam int ST_SHOW     = 0;
    localparam int ST_FADE_OUT = 1;
    localparam int ST_LOAD     = 2;
    localparam int ST_FADE_IN  = 3;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       pause;
    logic       skip;
    logic       render_done;
    logic [0:0] image_sel;
    logic       render_start;
    logic [3:0] brightness;
    logic       render_timeout;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    // Observed pulse counts over a directed window
    int start_pulses   = 0;
    int timeout_pulses = 0;

    // Reference model: the show as the sequence of phases it describes
    int m_phase;       // which phase of the show is on screen
    int m_img;         // image index in use
    int m_level;       // brightness 0..15
    int m_shown;       // frames shown of the current image
    int m_waited;      // frames waited for the renderer
    bit m_start;       // render kick issued last edge
    bit m_timeout;     // render abandoned last edge

    screensaver_sequencer #(
        .NUM_IMAGES            (N_IMG),
        .FRAMES_PER_IMAGE      (FPI),
        .RENDER_TIMEOUT_FRAMES (RT),
        .START_IMAGE           (START)
    ) dut (
        .clk_25_175     (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .pause          (pause),
        .skip           (skip),
        .render_done    (render_done),
        .image_sel      (image_sel),
        .render_start   (render_start),
        .brightness     (brightness),
        .render_timeout (render_timeout),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input bit r, input bit t, input bit p,
                              input bit s, input bit d);
        bit kick_was_high;
        kick_was_high = m_start;
        m_start   = 1'b0;
        m_timeout = 1'b0;
        if (r) begin
            m_phase  = ST_SHOW;
            m_img    = START;
            m_level  = 15;
            m_shown  = 0;
            m_waited = 0;
            return;
        end
        if (m_phase == ST_SHOW) begin
            if (s) begin
                m_shown = 0;
                m_phase = ST_FADE_OUT;
            end else if (t && !p) begin
                m_shown = m_shown + 1;
                if (m_shown == FPI) begin
                    m_shown = 0;
                    m_phase = ST_FADE_OUT;
                end
            end
        end else if (m_phase == ST_FADE_OUT) begin
            if (t) begin
                m_level = m_level - 1;
                if (m_level == 0) begin
                    m_img    = (m_img + 1) % N_IMG;
                    m_start  = 1'b1;
                    m_waited = 0;
                    m_phase  = ST_LOAD;
                end
            end
        end else if (m_phase == ST_LOAD) begin
            if (d && !kick_was_high) begin
                m_phase = ST_FADE_IN;
            end else if (t) begin
                m_waited = m_waited + 1;
                if (m_waited == RT) begin
                    m_timeout = 1'b1;
                    m_phase   = ST_FADE_IN;
                end
            end
        end else begin
            if (t) begin
                m_level = m_level + 1;
                if (m_level == 15) begin
                    m_shown = 0;
                    m_phase = ST_SHOW;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, take the edge, compare all outputs.
    task automatic cycle(input bit r, input bit t, input bit p,
                         input bit s, input bit d);
        rst         = r;
        frame_tick  = t;
        pause       = p;
        skip        = s;
        render_done = d;
        @(posedge clk);
        model_step(r, t, p, s, d);
        #1;
        check("state", int'(state), m_phase);
        check("image_sel", int'(image_sel), m_img);
        check("brightness", int'(brightness), m_level);
        check("render_start", int'(render_start), int'(m_start));
        check("render_timeout", int'(render_timeout), int'(m_timeout));
        if (render_start === 1'b1) start_pulses++;
        if (render_timeout === 1'b1) timeout_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // n frames, each an idle cycle followed by a tick cycle.
    task automatic frames(input int n, input bit p);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, p, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, p, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        pause       = 1'b0;
        skip        = 1'b0;
        render_done = 1'b0;
        m_phase = ST_SHOW; m_img = START; m_level = 15;
        m_shown = 0; m_waited = 0; m_start = 1'b0; m_timeout = 1'b0;

        // 1. Reset, show period, fade out, load with one start pulse.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("reset_state", int'(state), ST_SHOW);
        check("reset_brightness", int'(brightness), 15);
        check("reset_image_sel", int'(image_sel), START);
        check("reset_render_start", int'(render_start), 0);
        frames(FPI - 1, 1'b0);
        check("show_not_yet_expired", int'(state), ST_SHOW);
        frames(1, 1'b0);
        check("show_expired_fade_out", int'(state), ST_FADE_OUT);
        start_pulses = 0;
        frames(15, 1'b0);
        check("fade_out_to_load", int'(state), ST_LOAD);
        check("fade_out_black", int'(brightness), 0);
        check("load_image_sel_1", int'(image_sel), 1);
        idle(4);
        check("start_pulse_count", start_pulses, 1);

        // 2. Done five cycles after start, fade in, fresh show period.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("done_to_fade_in", int'(state), ST_FADE_IN);
        frames(15, 1'b0);
        check("fade_in_to_show", int'(state), ST_SHOW);
        check("fade_in_full", int'(brightness), 15);
        frames(FPI - 1, 1'b0);
        check("frame_cnt_restarted", int'(state), ST_SHOW);
        frames(1, 1'b0);
        check("second_fade_out", int'(state), ST_FADE_OUT);
        frames(15, 1'b0);
        check("image_wrap_to_0", int'(image_sel), 0);

        // 3. No done: timeout on the third load tick.
        timeout_pulses = 0;
        frames(RT - 1, 1'b0);
        check("load_waiting", int'(state), ST_LOAD);
        frames(1, 1'b0);
        check("timeout_pulse", int'(render_timeout), 1);
        check("timeout_to_fade_in", int'(state), ST_FADE_IN);
        check("timeout_keeps_image", int'(image_sel), 0);
        idle(1);
        check("timeout_pulse_count", timeout_pulses, 1);
        frames(15, 1'b0);

        // 4. Pause holds the show; skip coincident with a tick still wins.
        frames(10, 1'b1);
        check("pause_holds_show", int'(state), ST_SHOW);
        check("pause_full_bright", int'(brightness), 15);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("skip_to_fade_out", int'(state), ST_FADE_OUT);
        check("skip_bright_held", int'(brightness), 15);
        frames(15, 1'b0);
        check("load_image_sel_again", int'(image_sel), 1);

        // 5. Done alongside start ignored; done on the timeout tick wins.
        timeout_pulses = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("early_done_ignored", int'(state), ST_LOAD);
        frames(RT - 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("done_beats_timeout", int'(state), ST_FADE_IN);
        check("no_timeout_pulse", timeout_pulses, 0);
        frames(15, 1'b0);

        // 6. Reset mid fade-out, then a late done.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        frames(8, 1'b0);
        check("mid_fade_level", int'(brightness), 7);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_state", int'(state), ST_SHOW);
        check("mid_reset_bright", int'(brightness), 15);
        check("mid_reset_image", int'(image_sel), START);
        check("mid_reset_start", int'(render_start), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("late_done_ignored", int'(state), ST_SHOW);

        // 7. Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            bit r, t, p, s, d;
            r = ($urandom_range(799) == 0);
            t = ($urandom_range(2) == 0);
            p = ($urandom_range(3) == 0);
            s = ($urandom_range(59) == 0);
            d = ($urandom_range(9) == 0);
            cycle(r, t, p, s, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
